// File: rtl/axis_hist_lut_mapper_pkg.sv
// Shared constants for the histogram-equalization LUT path.
// These values must match the ones used by axis_hist_equalizer.
package axis_hist_lut_mapper_pkg;

  // Significant bits of a raw thermal pixel; also the LUT address width.
  localparam int HIST_PIX_W     = 14;

  // Width of one LUT entry and of one display pixel.
  localparam int HIST_OUT_W     = 8;

  // Number of entries in one LUT bank.
  localparam int HIST_LUT_DEPTH = 1 << HIST_PIX_W;

endpackage

// File: rtl/axis_hist_lut_mapper_hist_lut_pingpong_ram.sv
// Simple dual-port RAM that holds both LUT banks.
// The bank bit is the MSB of each address, so one memory serves the
// active read bank and the shadow write bank at the same time.
// The read data is registered and gated by a read enable, so the memory
// can hold its output during a downstream stall. This maps onto block RAM.
module hist_lut_pingpong_ram #(
  parameter int ADDR_W = 15,
  parameter int DATA_W = 8
) (
  input  logic              clk_i,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic              re_i,
  input  logic [ADDR_W-1:0] raddr_i,
  output logic [DATA_W-1:0] rdata_o
);

  logic [DATA_W-1:0] mem [0:(1<<ADDR_W)-1];
  logic [DATA_W-1:0] rdata_q;

  // Write port: the equalizer fills the shadow bank.
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem[waddr_i] <= wdata_i;
    end
  end

  // Registered read port; it holds its value while the read enable is low.
  always_ff @(posedge clk_i) begin
    if (re_i) begin
      rdata_q <= mem[raddr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/axis_hist_lut_mapper.sv
// Maps raw 14-bit thermal pixels to 8-bit display pixels through a
// ping-pong histogram-equalization LUT.
// Banks swap only on a start-of-frame pulse after a complete LUT has been
// written, so a single frame never mixes two LUTs.
module axis_hist_lut_mapper
  import axis_hist_lut_mapper_pkg::*;
#(
  parameter int PIX_W = HIST_PIX_W,
  parameter int OUT_W = HIST_OUT_W
) (
  input  logic             s_axis_aclk,
  input  logic             s_axis_aresetn,
  input  logic             sof,
  input  logic [15:0]      s_axis_tdata,
  input  logic             s_axis_tvalid,
  output logic             s_axis_tready,
  input  logic             s_axis_tlast,
  output logic [OUT_W-1:0] m_axis_tdata,
  output logic             m_axis_tvalid,
  input  logic             m_axis_tready,
  output logic             m_axis_tlast,
  input  logic             hist_lut_ram_we,
  input  logic [PIX_W-1:0] hist_lut_ram_addr,
  input  logic [OUT_W-1:0] hist_lut_ram_din,
  output logic             lut_valid,
  output logic             lut_bank
);

  logic             lutBank_q, lutBank_d;
  logic             pending_q, pending_d;
  logic             lutValid_q, lutValid_d;
  logic             ramWe;

  logic             adv;
  logic             accept;
  logic [PIX_W-1:0] satAddr;
  logic [OUT_W-1:0] bypassVal;
  logic [OUT_W-1:0] ramDout;

  logic             s1Valid_q;
  logic             s1Last_q;
  logic             s1Bypass_q;
  logic [OUT_W-1:0] s1BypVal_q;

  logic             mValid_q;
  logic             mLast_q;
  logic [OUT_W-1:0] mData_q;

  // The whole pipeline moves together. It only stops when a held output is not taken.
  assign adv           = !mValid_q || m_axis_tready;
  assign s_axis_tready = adv && s_axis_aresetn;
  assign accept        = s_axis_tvalid && s_axis_tready;

  // Out-of-range pixels saturate to the top LUT entry.
  assign satAddr   = (|s_axis_tdata[15:PIX_W]) ? {PIX_W{1'b1}} : s_axis_tdata[PIX_W-1:0];
  assign bypassVal = satAddr[PIX_W-1 -: OUT_W];

  // Bank control: fill the shadow bank until its last entry is written, freeze it, then swap on SOF.
  always_comb begin
    lutBank_d  = lutBank_q;
    pending_d  = pending_q;
    lutValid_d = lutValid_q;
    ramWe      = 1'b0;
    if (hist_lut_ram_we && !pending_q) begin
      ramWe = 1'b1;
      if (hist_lut_ram_addr == {PIX_W{1'b1}}) begin
        pending_d = 1'b1;
      end
    end
    if (sof && pending_q) begin
      lutBank_d  = ~lutBank_q;
      pending_d  = 1'b0;
      lutValid_d = 1'b1;
    end
  end

  // Register the bank-control state.
  always_ff @(posedge s_axis_aclk) begin
    if (!s_axis_aresetn) begin
      lutBank_q  <= 1'b0;
      pending_q  <= 1'b0;
      lutValid_q <= 1'b0;
    end else begin
      lutBank_q  <= lutBank_d;
      pending_q  <= pending_d;
      lutValid_q <= lutValid_d;
    end
  end

  // The bank is fixed into the read address here, so in-flight pixels keep the bank they sampled.
  hist_lut_pingpong_ram #(
    .ADDR_W (PIX_W + 1),
    .DATA_W (OUT_W)
  ) u_ram (
    .clk_i   (s_axis_aclk),
    .we_i    (ramWe),
    .waddr_i ({~lutBank_q, hist_lut_ram_addr}),
    .wdata_i (hist_lut_ram_din),
    .re_i    (adv),
    .raddr_i ({lutBank_q, satAddr}),
    .rdata_o (ramDout)
  );

  // Stage 1 captures the sideband signals alongside the RAM read.
  always_ff @(posedge s_axis_aclk) begin
    if (!s_axis_aresetn) begin
      s1Valid_q  <= 1'b0;
      s1Last_q   <= 1'b0;
      s1Bypass_q <= 1'b1;
      s1BypVal_q <= '0;
    end else if (adv) begin
      s1Valid_q  <= accept;
      s1Last_q   <= s_axis_tlast;
      s1Bypass_q <= !lutValid_q;
      s1BypVal_q <= bypassVal;
    end
  end

  // Stage 2 selects between the LUT result and the linear bypass, and drives the output registers.
  always_ff @(posedge s_axis_aclk) begin
    if (!s_axis_aresetn) begin
      mValid_q <= 1'b0;
      mLast_q  <= 1'b0;
      mData_q  <= '0;
    end else if (adv) begin
      mValid_q <= s1Valid_q;
      mLast_q  <= s1Last_q;
      mData_q  <= s1Bypass_q ? s1BypVal_q : ramDout;
    end
  end

  assign m_axis_tdata  = mData_q;
  assign m_axis_tvalid = mValid_q;
  assign m_axis_tlast  = mLast_q;
  assign lut_valid     = lutValid_q;
  assign lut_bank      = lutBank_q;

endmodule

// File: tb/tb_axis_hist_lut_mapper.sv
// Scoreboard testbench for axis_hist_lut_mapper.
// The reference model keeps both LUT banks as plain tables and applies the
// fill, freeze and swap rules at each clock edge. The expected output for a
// pixel is computed when the pixel is accepted, and a monitor compares it
// when the pixel leaves the design.
module tb_axis_hist_lut_mapper;

  localparam int DEPTH = 16384;

  logic        clk = 1'b0;
  logic        aresetn;
  logic        sof;
  logic [15:0] sTdata;
  logic        sTvalid;
  logic        sTready;
  logic        sTlast;
  logic [7:0]  mTdata;
  logic        mTvalid;
  logic        mTready;
  logic        mTlast;
  logic        lutWe;
  logic [13:0] lutAddr;
  logic [7:0]  lutDin;
  logic        lutValidO;
  logic        lutBankO;

  int testsRun    = 0;
  int testsFailed = 0;

  logic [8:0]  expQ[$];
  logic [7:0]  lutMem [2][DEPTH];
  bit          expBank     = 1'b0;
  bit          expPending  = 1'b0;
  bit          expLutValid = 1'b0;
  bit          bpEnable    = 1'b0;

  axis_hist_lut_mapper dut (
    .s_axis_aclk       (clk),
    .s_axis_aresetn    (aresetn),
    .sof               (sof),
    .s_axis_tdata      (sTdata),
    .s_axis_tvalid     (sTvalid),
    .s_axis_tready     (sTready),
    .s_axis_tlast      (sTlast),
    .m_axis_tdata      (mTdata),
    .m_axis_tvalid     (mTvalid),
    .m_axis_tready     (mTready),
    .m_axis_tlast      (mTlast),
    .hist_lut_ram_we   (lutWe),
    .hist_lut_ram_addr (lutAddr),
    .hist_lut_ram_din  (lutDin),
    .lut_valid         (lutValidO),
    .lut_bank          (lutBankO)
  );

  initial forever #5 clk = ~clk;

  // Compare one value and count the result.
  function automatic void checkOutput(input string name, input logic [31:0] actual,
                                      input logic [31:0] expected);
    testsRun++;
    if (actual !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s actual=%0h expected=%0h at %0t", name, actual, expected, $time);
    end
  endfunction

  // Reference mapping computed when the pixel is accepted.
  function automatic logic [7:0] expectOf(input logic [15:0] pix);
    int sat;
    sat = (pix > 16'(DEPTH - 1)) ? DEPTH - 1 : int'(pix);
    if (expLutValid) return lutMem[expBank ? 1 : 0][sat];
    return 8'(sat / 64);
  endfunction

  // Reference bank rules, applied at the edge where the inputs are sampled.
  function automatic void modelEdge(input bit weV, input int addr, input int din, input bit sofV);
    bit swapNow;
    swapNow = sofV && expPending;
    if (weV && !expPending) begin
      lutMem[expBank ? 0 : 1][addr] = 8'(din);
      if (addr == DEPTH - 1) expPending = 1'b1;
    end
    if (swapNow) begin
      expBank     = !expBank;
      expPending  = 1'b0;
      expLutValid = 1'b1;
    end
  endfunction

  // Output-ready driver: either always ready, or randomly stalled.
  initial begin
    mTready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      mTready = bpEnable ? ($urandom_range(0, 2) != 0) : 1'b1;
    end
  end

  // Monitor: pops the scoreboard on each output handshake and checks that outputs stay stable during stalls.
  initial begin
    logic [8:0] exp;
    logic [7:0] heldData;
    logic       heldLast;
    bit         holdActive;
    holdActive = 1'b0;
    heldData   = '0;
    heldLast   = 1'b0;
    forever begin
      @(negedge clk);
      if (aresetn) begin
        if (holdActive) begin
          checkOutput("stall_valid", 32'(mTvalid), 32'd1);
          checkOutput("stall_data", 32'(mTdata), 32'(heldData));
          checkOutput("stall_last", 32'(mTlast), 32'(heldLast));
        end
        if (mTvalid && mTready) begin
          holdActive = 1'b0;
          if (expQ.size() == 0) begin
            testsRun++;
            testsFailed++;
            $display("[TB] FAIL unexpected_output actual=%0h expected=none at %0t", mTdata, $time);
          end else begin
            exp = expQ.pop_front();
            checkOutput("out_data", 32'(mTdata), 32'(exp[7:0]));
            checkOutput("out_last", 32'(mTlast), 32'(exp[8]));
          end
        end else if (mTvalid) begin
          holdActive = 1'b1;
          heldData   = mTdata;
          heldLast   = mTlast;
        end else begin
          holdActive = 1'b0;
        end
      end else begin
        holdActive = 1'b0;
      end
    end
  end

  // Offer one pixel and wait for its handshake. Starts and ends 1 time unit after a rising edge.
  task automatic applyStimulus(input logic [15:0] pix, input bit last);
    int guard;
    guard   = 0;
    sTvalid = 1'b1;
    sTdata  = pix;
    sTlast  = last;
    forever begin
      @(negedge clk);
      if (sTready) begin
        expQ.push_back({last, expectOf(pix)});
        @(posedge clk);
        #1;
        break;
      end
      guard++;
      if (guard > 1000) begin
        testsRun++;
        testsFailed++;
        $display("[TB] FAIL input_handshake_timeout actual=0 expected=1");
        @(posedge clk);
        #1;
        break;
      end
      @(posedge clk);
      #1;
    end
    sTvalid = 1'b0;
    sTlast  = 1'b0;
  endtask

  // One LUT write, optionally in the same cycle as a start-of-frame pulse.
  task automatic lutWrite(input int addr, input int din, input bit withSof);
    lutWe   = 1'b1;
    lutAddr = 14'(addr);
    lutDin  = 8'(din);
    sof     = withSof;
    @(posedge clk);
    modelEdge(1'b1, addr, din, withSof);
    #1;
    lutWe = 1'b0;
    sof   = 1'b0;
  endtask

  // Single-cycle start-of-frame pulse.
  task automatic pulseSof();
    sof = 1'b1;
    @(posedge clk);
    modelEdge(1'b0, 0, 0, 1'b1);
    #1;
    sof = 1'b0;
  endtask

  // Wait until every expected pixel has come out, within a bounded number of cycles.
  task automatic drain();
    int guard;
    guard = 0;
    while (expQ.size() != 0 && guard < 5000) begin
      @(posedge clk);
      guard++;
    end
    if (expQ.size() != 0) begin
      testsRun++;
      testsFailed++;
      $display("[TB] FAIL drain_timeout actual=%0d expected=0", expQ.size());
    end
    repeat (3) @(posedge clk);
    #1;
  endtask

  // Global time limit.
  initial begin
    #3ms;
    $display("[TB] FAIL watchdog_timeout actual=running expected=finished");
    $fatal(1, "[TB] watchdog expired");
  end

  // Main sequence.
  initial begin
    logic [31:0] r;
    logic [15:0] pix;
    aresetn = 1'b0;
    sof     = 1'b0;
    sTdata  = '0;
    sTvalid = 1'b0;
    sTlast  = 1'b0;
    lutWe   = 1'b0;
    lutAddr = '0;
    lutDin  = '0;

    repeat (3) @(posedge clk);
    #1;
    checkOutput("rst_m_tvalid", 32'(mTvalid), 32'd0);
    checkOutput("rst_m_tdata", 32'(mTdata), 32'd0);
    checkOutput("rst_m_tlast", 32'(mTlast), 32'd0);
    checkOutput("rst_s_tready", 32'(sTready), 32'd0);
    aresetn = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("rst_lut_valid", 32'(lutValidO), 32'd0);
    checkOutput("rst_lut_bank", 32'(lutBankO), 32'd0);
    checkOutput("ready_after_rst", 32'(sTready), 32'd1);

    $display("[TB] bypass map and latency");
    applyStimulus(16'h0000, 1'b0);
    checkOutput("latency_n1", 32'(mTvalid), 32'd0);
    @(posedge clk);
    #1;
    checkOutput("latency_n2", 32'(mTvalid), 32'd1);
    applyStimulus(16'h1FC0, 1'b0);
    applyStimulus(16'h3FFF, 1'b1);
    drain();

    $display("[TB] first LUT fill and swap");
    for (int a = 0; a < DEPTH; a++) lutWrite(a, (~a) & 8'hFF, 1'b0);
    checkOutput("pending_no_swap_bank", 32'(lutBankO), 32'd0);
    checkOutput("pending_no_swap_valid", 32'(lutValidO), 32'd0);
    pulseSof();
    checkOutput("swap1_bank", 32'(lutBankO), 32'(expBank));
    checkOutput("swap1_valid", 32'(lutValidO), 32'd1);
    applyStimulus(16'h0005, 1'b0);
    applyStimulus(16'hC123, 1'b1);
    drain();

    $display("[TB] second LUT, frozen shadow, deferred swap");
    for (int a = 0; a < DEPTH; a++) lutWrite(a, int'($urandom_range(0, 255)), 1'b0);
    lutWrite(0, 8'h55, 1'b0);
    pulseSof();
    checkOutput("swap2_bank", 32'(lutBankO), 32'(expBank));
    applyStimulus(16'h0000, 1'b1);
    pulseSof();
    checkOutput("idle_sof_bank", 32'(lutBankO), 32'(expBank));
    lutWrite(DEPTH - 1, 8'hA5, 1'b1);
    checkOutput("same_cycle_no_swap", 32'(lutBankO), 32'(expBank));
    pulseSof();
    checkOutput("swap3_bank", 32'(lutBankO), 32'(expBank));
    applyStimulus(16'h3FFF, 1'b0);
    applyStimulus(16'h0005, 1'b1);
    drain();

    $display("[TB] 640-pixel line with random backpressure");
    bpEnable = 1'b1;
    for (int i = 0; i < 640; i++) begin
      r   = $urandom;
      pix = (r[3:0] == 4'd0) ? r[31:16] : {2'b00, r[29:16]};
      applyStimulus(pix, i == 639);
    end
    drain();
    bpEnable = 1'b0;
    @(posedge clk);
    #1;

    $display("[TB] reset with pixels in flight");
    applyStimulus(16'h0100, 1'b0);
    applyStimulus(16'h0200, 1'b1);
    aresetn = 1'b0;
    expQ.delete();
    expBank     = 1'b0;
    expPending  = 1'b0;
    expLutValid = 1'b0;
    @(posedge clk);
    #1;
    checkOutput("midrst_m_tvalid", 32'(mTvalid), 32'd0);
    checkOutput("midrst_m_tdata", 32'(mTdata), 32'd0);
    checkOutput("midrst_m_tlast", 32'(mTlast), 32'd0);
    checkOutput("midrst_s_tready", 32'(sTready), 32'd0);
    checkOutput("midrst_lut_valid", 32'(lutValidO), 32'd0);
    checkOutput("midrst_lut_bank", 32'(lutBankO), 32'd0);
    aresetn = 1'b1;
    @(posedge clk);
    #1;
    applyStimulus(16'h2ABC, 1'b1);
    drain();
    repeat (5) @(posedge clk);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
